seq_alu_mul: RTL

//  Parametrised, registered successor to the combinational datapath ALU. Performs single-cycle

---
 rtl/seq_alu_mul_if.sv | 24 ++
 rtl/seq_alu_mul.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_mul_if.sv
// Control-unit <-> ALU handshake bundle: request operands in, result/status out.
interface seq_alu_mul_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, flags
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, flags
    );
endinterface

// File: rtl/seq_alu_mul.sv
// Registered ALU with single-cycle arith/logic/shift ops and an iterative
// shift-add multiplier (unsigned MUL, signed MLS) producing a 2*WIDTH product.
module seq_alu_mul #(
    parameter int unsigned WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_alu_mul_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_SBC = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_INV = 4'h8;
    localparam logic [3:0] OP_TWC = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;
    localparam logic [3:0] OP_LSR = 4'hC;
    localparam logic [3:0] OP_ASR = 4'hD;
    localparam logic [3:0] OP_MUL = 4'hE;
    localparam logic [3:0] OP_MLS = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic               mul_neg;

    logic               busy_q, done_q;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic [3:0]         flags_q;  // {V,C,N,Z}

    logic accept_single, accept_mul, step, finish;
    logic busy_nx, done_nx;

    logic [WIDTH-1:0]   add_x, add_y;
    logic               add_ci, use_add;
    logic [WIDTH:0]     add_sum;
    logic               add_v;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c, alu_v;

    logic               is_mls, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mstep_add, mstep_sum;
    logic [2*WIDTH-1:0] step_prod, mul_final;

    // Single-cycle datapath: every carry-producing op routes through one adder.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_ci  = 1'b0;
        use_add = 1'b0;
        alu_r   = '0;
        alu_c   = flags_q[2];
        alu_v   = 1'b0;
        case (bus.op)
            OP_MOV: alu_r = bus.a;
            OP_ADD: begin add_x = bus.a;  add_y = bus.b;  use_add = 1'b1; end
            OP_ADC: begin add_x = bus.a;  add_y = bus.b;  add_ci = flags_q[2]; use_add = 1'b1; end
            OP_SUB: begin add_x = bus.a;  add_y = ~bus.b; add_ci = 1'b1; use_add = 1'b1; end
            OP_SBC: begin add_x = bus.a;  add_y = ~bus.b; add_ci = flags_q[2]; use_add = 1'b1; end
            OP_AND: alu_r = bus.a & bus.b;
            OP_OR:  alu_r = bus.a | bus.b;
            OP_XOR: alu_r = bus.a ^ bus.b;
            OP_INV: alu_r = ~bus.a;
            OP_TWC: begin add_x = ~bus.a; add_ci = 1'b1; use_add = 1'b1; end
            OP_INC: begin add_x = bus.a;  add_ci = 1'b1; use_add = 1'b1; end
            OP_DEC: begin add_x = bus.a;  add_y = '1;    use_add = 1'b1; end
            OP_LSR: begin alu_r = {1'b0, bus.a[WIDTH-1:1]};           alu_c = bus.a[0]; end
            OP_ASR: begin alu_r = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]}; alu_c = bus.a[0]; end
            default: alu_r = '0;
        endcase
        add_sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_ci);
        add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
        if (use_add) begin
            alu_r = add_sum[WIDTH-1:0];
            alu_c = add_sum[WIDTH];
            alu_v = add_v;
        end
    end

    // Multiplier operand conditioning and one shift-add step.
    always_comb begin
        is_mls    = (bus.op == OP_MLS);
        a_neg     = is_mls & bus.a[WIDTH-1];
        b_neg     = is_mls & bus.b[WIDTH-1];
        mag_a     = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        mag_b     = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
        mstep_add = prod[0] ? {1'b0, mcand} : '0;
        mstep_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + mstep_add;
        step_prod = {mstep_sum, prod[WIDTH-1:1]};
        mul_final = mul_neg ? (~step_prod + (2*WIDTH)'(1)) : step_prod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state and control strobes; the last multiply step writes results directly.
    always_comb begin
        next_state    = state;
        accept_single = 1'b0;
        accept_mul    = 1'b0;
        step          = 1'b0;
        finish        = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op >= OP_MUL) begin
                        accept_mul = 1'b1;
                        next_state = S_MUL;
                    end else begin
                        accept_single = 1'b1;
                    end
                end
            end
            S_MUL: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    finish     = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        busy_nx = (next_state == S_MUL);
        done_nx = accept_single | finish;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            cnt     <= '0;
            mcand   <= '0;
            prod    <= '0;
            mul_neg <= 1'b0;
        end else begin
            busy_q <= busy_nx;
            done_q <= done_nx;
            if (accept_single) begin
                lo_q    <= alu_r;
                hi_q    <= '0;
                flags_q <= {alu_v, alu_c, alu_r[WIDTH-1], (alu_r == '0)};
            end
            if (accept_mul) begin
                mcand   <= mag_a;
                prod    <= {{WIDTH{1'b0}}, mag_b};
                mul_neg <= a_neg ^ b_neg;
                cnt     <= '0;
            end
            if (step) begin
                prod <= step_prod;
                cnt  <= cnt + CNT_W'(1);
            end
            if (finish) begin
                lo_q    <= mul_final[WIDTH-1:0];
                hi_q    <= mul_final[2*WIDTH-1:WIDTH];
                flags_q <= {1'b0, flags_q[2], mul_final[2*WIDTH-1], (mul_final == '0)};
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_lo = lo_q;
    assign bus.result_hi = hi_q;
    assign bus.flags     = flags_q;
endmodule
